// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register with load-use hazard detection and bubble insertion.
// Optional load-use bubble counter enabled by DECODE_EXECUTE_PERF_COUNTER_EN.
module decode_execute_register #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pc_decode,
    input  logic [DATA_WIDTH-1:0] rs1_data_decode,
    input  logic [DATA_WIDTH-1:0] rs2_data_decode,
    input  logic [DATA_WIDTH-1:0] immediate_decode,
    input  logic [4:0]            rs1_index_decode,
    input  logic [4:0]            rs2_index_decode,
    input  logic [4:0]            rd_index_decode,
    input  logic                  rs1_used_decode,
    input  logic                  rs2_used_decode,
    input  logic                  valid_decode,
    input  logic                  register_write_enable_decode,
    input  logic                  memory_read_enable_decode,
    input  logic                  memory_write_enable_decode,
    input  logic [3:0]            alu_operation_decode,
    input  logic                  alu_source_b_select_decode,
    input  logic [1:0]            writeback_select_decode,
    input  logic                  stall_pipeline,
    input  logic                  flush_execute,
    output logic [DATA_WIDTH-1:0] pc_execute,
    output logic [DATA_WIDTH-1:0] rs1_data_execute,
    output logic [DATA_WIDTH-1:0] rs2_data_execute,
    output logic [DATA_WIDTH-1:0] immediate_execute,
    output logic [4:0]            rs1_index_execute,
    output logic [4:0]            rs2_index_execute,
    output logic [4:0]            rd_index_execute,
    output logic                  valid_execute,
    output logic                  register_write_enable_execute,
    output logic                  memory_read_enable_execute,
    output logic                  memory_write_enable_execute,
    output logic [3:0]            alu_operation_execute,
    output logic                  alu_source_b_select_execute,
    output logic [1:0]            writeback_select_execute,
`ifdef DECODE_EXECUTE_PERF_COUNTER_EN
    output logic [31:0]           bubble_count,
`endif
    output logic                  load_use_stall
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_immediate;
    logic [4:0]            r_rs1_index;
    logic [4:0]            r_rs2_index;
    logic [4:0]            r_rd_index;
    logic                  r_valid;
    logic                  r_register_write_enable;
    logic                  r_memory_read_enable;
    logic                  r_memory_write_enable;
    logic [3:0]            r_alu_operation;
    logic                  r_alu_source_b_select;
    logic [1:0]            r_writeback_select;

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_raw_hazard;

    // Hazard only against a live load writing a real register (x0 never forwards).
    always_comb begin
        w_rs1_match  = rs1_used_decode && valid_decode && (rs1_index_decode == r_rd_index);
        w_rs2_match  = rs2_used_decode && valid_decode && (rs2_index_decode == r_rd_index);
        w_raw_hazard = r_valid && r_memory_read_enable && (r_rd_index != 5'd0)
                       && (w_rs1_match || w_rs2_match);
    end

    assign load_use_stall = w_raw_hazard && !flush_execute;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_execute || (!stall_pipeline && load_use_stall)) begin
            r_pc                    <= '0;
            r_rs1_data              <= '0;
            r_rs2_data              <= '0;
            r_immediate             <= '0;
            r_rs1_index             <= '0;
            r_rs2_index             <= '0;
            r_rd_index              <= '0;
            r_valid                 <= 1'b0;
            r_register_write_enable <= 1'b0;
            r_memory_read_enable    <= 1'b0;
            r_memory_write_enable   <= 1'b0;
            r_alu_operation         <= '0;
            r_alu_source_b_select   <= 1'b0;
            r_writeback_select      <= '0;
        end else if (!stall_pipeline) begin
            r_pc                    <= pc_decode;
            r_rs1_data              <= rs1_data_decode;
            r_rs2_data              <= rs2_data_decode;
            r_immediate             <= immediate_decode;
            r_rs1_index             <= rs1_index_decode;
            r_rs2_index             <= rs2_index_decode;
            r_rd_index              <= rd_index_decode;
            r_valid                 <= valid_decode;
            r_register_write_enable <= register_write_enable_decode && valid_decode;
            r_memory_read_enable    <= memory_read_enable_decode && valid_decode;
            r_memory_write_enable   <= memory_write_enable_decode && valid_decode;
            r_alu_operation         <= alu_operation_decode & {4{valid_decode}};
            r_alu_source_b_select   <= alu_source_b_select_decode && valid_decode;
            r_writeback_select      <= writeback_select_decode & {2{valid_decode}};
        end
    end

`ifdef DECODE_EXECUTE_PERF_COUNTER_EN
    logic [31:0] r_bubble_count;

    // load_use_stall already excludes flush, so only load-use bubbles are counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else if (!stall_pipeline && load_use_stall && (r_bubble_count != 32'hFFFF_FFFF)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign bubble_count = r_bubble_count;
`endif

    assign pc_execute                    = r_pc;
    assign rs1_data_execute              = r_rs1_data;
    assign rs2_data_execute              = r_rs2_data;
    assign immediate_execute             = r_immediate;
    assign rs1_index_execute             = r_rs1_index;
    assign rs2_index_execute             = r_rs2_index;
    assign rd_index_execute              = r_rd_index;
    assign valid_execute                 = r_valid;
    assign register_write_enable_execute = r_register_write_enable;
    assign memory_read_enable_execute    = r_memory_read_enable;
    assign memory_write_enable_execute   = r_memory_write_enable;
    assign alu_operation_execute         = r_alu_operation;
    assign alu_source_b_select_execute   = r_alu_source_b_select;
    assign writeback_select_execute      = r_writeback_select;

endmodule

// File: doc/decode_execute_register.md
DECODE_EXECUTE_REGISTER -- requirements
Module: decode_execute_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of pc, operand data and immediate.
REQ-002 SHALL have ports clk (input, 1, rising-edge clock) and rst_n (input, 1, synchronous active-low reset).
REQ-003 SHALL have inputs pc_decode (DATA_WIDTH), rs1_data_decode (DATA_WIDTH), rs2_data_decode (DATA_WIDTH) and immediate_decode (DATA_WIDTH), carrying the decode-stage payload.
REQ-004 SHALL have inputs rs1_index_decode (5), rs2_index_decode (5), rd_index_decode (5), rs1_used_decode (1) and rs2_used_decode (1).
REQ-005 SHALL have decode-stage control inputs valid_decode (1), register_write_enable_decode (1), memory_read_enable_decode (1), memory_write_enable_decode (1), alu_operation_decode (4), alu_source_b_select_decode (1) and writeback_select_decode (2).
REQ-006 SHALL have inputs stall_pipeline (1), a global hold from the memory system, and flush_execute (1), a branch or exception kill.
REQ-007 SHALL provide a registered output *_execute of identical width for every *_decode input in REQ-003 to REQ-005, except rs1_used and rs2_used.
REQ-008 SHALL have output load_use_stall (1, combinational), the request for decode and fetch to hold.

Function
REQ-009 Each rising clk edge SHALL update the register by the first true case, in this order:
 - reset;
 - flush_execute: bubble;
 - stall_pipeline: hold;
 - load_use_stall: bubble;
 - otherwise: capture all *_decode inputs.
REQ-010 A bubble SHALL set valid_execute and every control output to 0, and all index outputs to 0.
REQ-010 (cont.) A bubble SHALL leave pc, data and immediate outputs don't-care; the implementation SHALL zero them.
REQ-011 Capture SHALL gate control outputs with valid_decode, so an invalid decode slot yields zero enables.
REQ-012 Raw hazard SHALL be true when all of the following hold:
 - valid_execute and memory_read_enable_execute are 1;
 - rd_index_execute is not 0;
 - either (rs1_used_decode, valid_decode and rs1_index_decode equals rd_index_execute) or the same condition for rs2.
REQ-013 load_use_stall SHALL equal raw hazard AND NOT flush_execute, and SHALL NOT depend on stall_pipeline.
REQ-014 Latency SHALL be one cycle from decode input to execute output, with no combinational path from any *_decode input to any *_execute output.
REQ-015 After a load-use bubble, the held decode instruction SHALL be captured on the next edge, provided stall_pipeline and flush_execute are low; the load is then in memory stage, and the downstream path forwards from writeback.
REQ-016 When flush_execute and stall_pipeline are both high, the register SHALL take the bubble; flush wins.
REQ-017 A zeroed index in a bubble SHALL guarantee no downstream forwarding match on x0.

Reset
REQ-018 While rst_n is 0 at a clk edge, the register SHALL clear every *_execute output to 0, so valid_execute is 0.
REQ-019 load_use_stall SHALL be 0 in the cycle following reset.
REQ-020 Reset SHALL take priority over flush, stall and capture, including mid-stall.

Configuration
REQ-021 When DECODE_EXECUTE_PERF_COUNTER_EN is defined, the block SHALL add output bubble_count (32).
REQ-022 bubble_count SHALL count edges on which a load-use bubble is inserted by REQ-009; flush bubbles are not counted.
REQ-023 bubble_count SHALL saturate at 32'hFFFFFFFF and SHALL clear on reset.
REQ-024 When DECODE_EXECUTE_PERF_COUNTER_EN is undefined, bubble_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 Basic capture: valid add, rs1=3, rs2=4, rd=5, register_write_enable=1 -> next cycle valid_execute=1, indices 3/4/5, register_write_enable_execute=1.
REQ-026 Load-use bubble:
 - Stimulus: execute holds lw with rd=7; decode holds add with rs2=7 and rs2_used=1.
 - Response: load_use_stall=1; next cycle valid_execute=0 with all indices 0; the following cycle the add is captured.
REQ-027 Load-use false positives:
 - execute lw with rd=0 and decode rs1=0 -> load_use_stall=0;
 - decode rs2=7 with rs2_used=0 -> load_use_stall=0.
REQ-028 Simultaneous events:
 - flush_execute=1 during a load-use hazard with stall_pipeline=1 -> load_use_stall=0, next cycle bubble;
 - stall_pipeline=1 alone for 3 cycles -> outputs unchanged throughout.
REQ-029 Reset mid-operation: rst_n=0 while stalled with valid_execute=1 -> next edge all outputs 0; with the macro defined, bubble_count=0.
REQ-030 Counter: with the macro defined, 3 load-use bubbles plus 2 flushes -> bubble_count=3; preload to FFFFFFFF plus one bubble -> bubble_count stays FFFFFFFF.
